countdown_bcd_display: RTL and testbench
========================================

# countdown_bcd_display

Parametrised multi-digit BCD countdown timer with integrated seven-segment drivers for the game's round/shot countdown. It generalises the single-digit countdown display to DIGITS digits and adds load, start, pause/resume, expiry signalling and BCD validation. The state manager controls it, and it drives HEX outputs directly from the 50 MHz board clock.

## Interface
Parameters:
- DIGITS, 3: number of BCD digits (1..6).
- CLK_HZ, 50_000_000: frequency of clk.
- TICK_HZ, 1: decrement rate. TICK_DIV = CLK_HZ/TICK_HZ, which must be ≥ 2 (elaboration check).
- SEG_ACTIVE_LOW, 1: segment polarity. 1 means a segment is lit when 0.

Ports:
- clk, in, 1: 50 MHz system clock. Single clock domain.
- reset, in, 1: synchronous, active-high.
- load, in, 1: one-cycle strobe that captures load_value and returns to IDLE.
- load_value, in, 4*DIGITS: BCD, digit 0 in [3:0].
- start, in, 1: begin or resume counting.
- pause, in, 1: freeze counting.
- count_bcd, out, 4*DIGITS: current value.
- segments, out, 7*DIGITS: per digit {g,f,e,d,c,b,a}. Digit 0 is in [6:0].
- running, out, 1: high in RUN.
- expired, out, 1: high in EXPIRED.
- done, out, 1: one-cycle pulse on entry to EXPIRED.
- load_err, out, 1: one-cycle pulse when load_value contained a digit > 9.

## Operation
- **States:** IDLE, RUN, PAUSED, EXPIRED.
- **Priority, highest first:** reset, load, start/pause.
- **load (any state):**
  - count ← load_value, with every digit > 9 clamped to 9.
  - load_err pulses if any clamp occurred.
  - Prescaler ← 0; state → IDLE.
  - start or pause in the same cycle is ignored.
- **IDLE:**
  - start with count ≠ 0 → RUN.
  - start with count = 0 → EXPIRED, with done pulse.
  - pause is ignored.
- **RUN:**
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and a tick occurs.
  - On a tick, count is decremented by one using a BCD borrow chain: a digit at 0 becomes 9 and borrows from the next digit.
  - If the decremented value is 0 → EXPIRED, with done pulse.
  - pause → PAUSED. Prescaler is held with no tick that cycle.
  - start is ignored.
- **PAUSED:**
  - Prescaler and count are held.
  - start without pause → RUN; the prescaler resumes from its held value.
  - start and pause together → stay PAUSED.
- **EXPIRED:**
  - count holds at 0.
  - start and pause are ignored. Only load or reset leaves this state.
- **Segment decode:** BCD 0..9 to standard glyphs. Active-low encodings: 0 = 1000000, 1 = 1111001, 9 = 0010000. SEG_ACTIVE_LOW=0 inverts these.
- **Arithmetic:** the prescaler is $clog2(TICK_DIV) bits wide. The count never underflows below 0.

## Timing
- All outputs are registered. Reset values:
  - state IDLE, count 0, prescaler 0.
  - running 0, expired 0, done 0, load_err 0.
  - segments = glyph "0" on every digit.
- count_bcd, running, expired, done and load_err all update on the same edge as the state change that causes them.
- segments lags count_bcd by exactly one cycle, because of the registered decode.
- First tick after start from IDLE: TICK_DIV cycles after the start edge. Subsequent ticks follow every TICK_DIV cycles.
- done is high for exactly one cycle per expiry, including the start-at-zero case.
- A load in the same cycle as a terminal tick wins: the new value is taken and there is no done pulse.
- Reset asserted mid-RUN returns all reset values on the next edge. No done pulse is generated.

## Structure
- **Shared include `countdown_defs.vh`:** state encodings (2-bit), the segment glyph constants for 0..9 and blank, and the SEG_ACTIVE_LOW convention. These are reused by the power-selection display.
- **Sub-module `bcd_to_seg`:** combinational digit decoder with a polarity parameter. It is instantiated DIGITS times via generate, with the output register held in the parent.
- **Parent contents:** FSM, prescaler, borrow-chain decrement, clamp logic.

## Test plan
Bench parameters: DIGITS=3, CLK_HZ=10, TICK_HZ=1, so TICK_DIV=10.

- **Load and count through borrow:** load 0x102, then start. Count must reach 0x101 at cycle 10, 0x100 at cycle 20 and 0x099 at cycle 30. segments digit 0 shows 0010000 one cycle after count.
- **Expiry:** load 0x002, then start. After 20 cycles count = 0x000, expired = 1 and done is a single one-cycle pulse. Further start pulses produce no change.
- **Pause and resume:**
  - During RUN, pause after 4 prescaler cycles and hold PAUSED for 50 cycles; count must not change.
  - Then start; the next tick comes 6 cycles later.
  - Asserting start and pause together while PAUSED leaves the block PAUSED.
- **Invalid load:** load 0xA5F. count must become 0x959, with load_err high for exactly 1 cycle.
- **Start at zero, and load-versus-tick collision:**
  - Load 0, then start: EXPIRED on the next edge with a done pulse.
  - Load 0x001, start, then apply load 0x050 on the terminal-tick cycle: count = 0x050, state IDLE, done stays 0.
- **Reset mid-RUN:** assert reset during a count from 0x123. The next edge gives count 0, all flags 0, and "0" glyphs one cycle later, with no done pulse.

Source files
------------

// File: rtl/countdown_bcd_display_pkg.sv
// Shared definitions for the BCD countdown displays: FSM states and seven-segment glyphs.
// Glyphs are stored active-high {g,f,e,d,c,b,a}; seg_polarity() applies the board polarity.
package countdown_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

    // Active-low boards light a segment by driving it to 0.
    function automatic logic [6:0] seg_polarity(input logic [6:0] glyph, input logic active_low);
        return active_low ? ~glyph : glyph;
    endfunction

endpackage

// File: rtl/countdown_bcd_display_if.sv
// Control/status bundle between the state manager (master) and the countdown display (slave).
interface countdown_bcd_display_if #(
    parameter int DIGITS = 3
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [7*DIGITS-1:0]   segments;
    logic                  running;
    logic                  expired;
    logic                  done;
    logic                  load_err;

    modport master (
        output load, load_value, start, pause,
        input  count_bcd, segments, running, expired, done, load_err
    );

    modport slave (
        input  load, load_value, start, pause,
        output count_bcd, segments, running, expired, done, load_err
    );
endinterface

// File: rtl/countdown_bcd_display_bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder; zero latency, no flow control.
// Codes above 9 decode to a blank digit.
module bcd_to_seg
    import countdown_bcd_display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    assign o_seg = seg_polarity(seg_glyph(i_digit), ACTIVE_LOW != 0);
endmodule

// File: rtl/countdown_bcd_display.sv
// Multi-digit BCD countdown timer with load/start/pause, expiry pulse and registered segment drivers.
// Status outputs follow the causing edge; segments lag count_bcd by one cycle. No backpressure.
module countdown_bcd_display
    import countdown_bcd_display_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    countdown_bcd_display_if.slave  bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int CW       = 4 * DIGITS;
    localparam int SW       = 7 * DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    SEG_ZERO   = seg_polarity(seg_glyph(4'd0), SEG_ACTIVE_LOW != 0);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("countdown_bcd_display: CLK_HZ/TICK_HZ must be at least 2");
    end

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt, w_clamped, w_dec;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [SW-1:0]   r_seg, w_seg_dec;
    logic            r_running, r_expired, r_done, r_load_err;
    logic            w_done_nxt, w_err_nxt, w_clamp_any;

    always_comb begin
        w_clamped   = '0;
        w_clamp_any = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > BCD_MAX) begin
                w_clamped[4*i +: 4] = BCD_MAX;
                w_clamp_any         = 1'b1;
            end else begin
                w_clamped[4*i +: 4] = bus.load_value[4*i +: 4];
            end
        end
    end

    // Borrow ripples upward through zero digits; only used while count is non-zero.
    always_comb begin : p_dec
        logic borrow;
        borrow = 1'b1;
        w_dec  = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = BCD_MAX;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (bus.load) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = w_clamped;
            w_presc_nxt = '0;
            w_err_nxt   = w_clamp_any;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (r_count == '0) begin
                            w_state_nxt = ST_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_count_nxt = w_dec;
                        if (w_dec == '0) begin
                            w_state_nxt = ST_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_EXPIRED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_seg      <= {DIGITS{SEG_ZERO}};
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_presc    <= w_presc_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_expired  <= (w_state_nxt == ST_EXPIRED);
            r_done     <= w_done_nxt;
            r_load_err <= w_err_nxt;
            r_seg      <= w_seg_dec;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .i_digit (r_count[4*g +: 4]),
            .o_seg   (w_seg_dec[7*g +: 7])
        );
    end

    assign bus.count_bcd = r_count;
    assign bus.segments  = r_seg;
    assign bus.running   = r_running;
    assign bus.expired   = r_expired;
    assign bus.done      = r_done;
    assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_countdown_bcd_display.sv
// Bench for countdown_bcd_display: decimal-value reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_countdown_bcd_display;
    localparam int ND       = 3;
    localparam int TICK_DIV = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_bcd_display_if #(.DIGITS(ND)) bus ();

    countdown_bcd_display #(
        .DIGITS(ND), .CLK_HZ(10), .TICK_HZ(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Standard active-low glyphs, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph_al(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] segs_of(input int v);
        logic [7*ND-1:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = glyph_al((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference model: count held as an ordinary integer, mode as the four named states.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
    int m_val = 0, m_prev = 0, m_mode = M_IDLE, m_phase = 0;
    bit m_done = 1'b0, m_err = 1'b0;

    always @(posedge clk) begin : model
        int v, md, ph, p, d;
        bit dn, er;
        v = m_val; md = m_mode; ph = m_phase; dn = 1'b0; er = 1'b0;
        if (reset) begin
            m_prev <= 0;
            v = 0; md = M_IDLE; ph = 0;
        end else begin
            m_prev <= m_val;
            if (bus.load) begin
                v = 0; p = 1;
                for (int i = 0; i < ND; i++) begin
                    d = int'(bus.load_value[4*i +: 4]);
                    if (d > 9) begin
                        d = 9;
                        er = 1'b1;
                    end
                    v = v + d * p;
                    p = p * 10;
                end
                md = M_IDLE; ph = 0;
            end else if (md == M_IDLE) begin
                if (bus.start) begin
                    if (v == 0) begin
                        md = M_EXP; dn = 1'b1;
                    end else begin
                        md = M_RUN;
                    end
                end
            end else if (md == M_RUN) begin
                if (bus.pause) begin
                    md = M_PAUSED;
                end else begin
                    ph = ph + 1;
                    if (ph == TICK_DIV) begin
                        ph = 0;
                        v = v - 1;
                        if (v == 0) begin
                            md = M_EXP; dn = 1'b1;
                        end
                    end
                end
            end else if (md == M_PAUSED) begin
                if (bus.start && !bus.pause) md = M_RUN;
            end
        end
        m_val <= v; m_mode <= md; m_phase <= ph; m_done <= dn; m_err <= er;
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (chk_en) begin
            check("m_count",   32'(bus.count_bcd), 32'(to_bcd(m_val)));
            check("m_seg",     32'(bus.segments),  32'(segs_of(m_prev)));
            check("m_running", 32'(bus.running),   32'(m_mode == M_RUN));
            check("m_expired", 32'(bus.expired),   32'(m_mode == M_EXP));
            check("m_done",    32'(bus.done),      32'(m_done));
            check("m_loaderr", 32'(bus.load_err),  32'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [4*ND-1:0] v);
        bus.load = 1'b1;
        bus.load_value = v;
        step(1);
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    int d0;

    initial begin
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0; bus.pause = 1'b0;
        reset = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(1);
        check("rst_count", 32'(bus.count_bcd), 32'h0);
        check("rst_seg",   32'(bus.segments), 32'({3{7'b1000000}}));
        check("rst_flags", 32'({bus.running, bus.expired, bus.done, bus.load_err}), 32'h0);
        reset = 1'b0;

        // Count through borrows from 102.
        do_load(12'h102);
        do_start();
        step(9);  check("s1_c9",  32'(bus.count_bcd), 32'h102);
        step(1);  check("s1_c10", 32'(bus.count_bcd), 32'h101);
        step(10); check("s1_c20", 32'(bus.count_bcd), 32'h100);
        step(10); check("s1_c30", 32'(bus.count_bcd), 32'h099);
        check("s1_seg_lag", 32'(bus.segments[6:0]), 32'(7'b1000000));
        step(1);  check("s1_seg0", 32'(bus.segments[6:0]), 32'(7'b0010000));
        check("s1_seg1", 32'(bus.segments[13:7]), 32'(7'b0010000));

        // Expiry from 002.
        do_load(12'h002);
        d0 = done_cnt;
        do_start();
        step(19); check("s2_c19", 32'(bus.count_bcd), 32'h001);
        check("s2_notexp", 32'(bus.expired), 32'h0);
        step(1);  check("s2_c20", 32'(bus.count_bcd), 32'h000);
        check("s2_exp",  32'(bus.expired), 32'h1);
        check("s2_done", 32'(bus.done), 32'h1);
        step(1);  check("s2_done_off", 32'(bus.done), 32'h0);
        do_start();
        step(3);
        check("s2_hold", 32'(bus.count_bcd), 32'h000);
        check("s2_exp2", 32'(bus.expired), 32'h1);
        check("s2_npulse", 32'(done_cnt - d0), 32'd1);

        // Pause after 4 prescaler cycles, resume, then start+pause while paused.
        do_load(12'h050);
        do_start();
        step(4);
        bus.pause = 1'b1; step(1); bus.pause = 1'b0;
        step(50);
        check("s3_paused_cnt", 32'(bus.count_bcd), 32'h050);
        check("s3_paused_run", 32'(bus.running), 32'h0);
        do_start();
        step(5); check("s3_pre_tick", 32'(bus.count_bcd), 32'h050);
        step(1); check("s3_tick",     32'(bus.count_bcd), 32'h049);
        bus.pause = 1'b1; step(1);
        bus.start = 1'b1; step(1);
        bus.start = 1'b0; bus.pause = 1'b0;
        step(12);
        check("s3_both_run", 32'(bus.running), 32'h0);
        check("s3_both_cnt", 32'(bus.count_bcd), 32'h049);

        // Invalid digits are clamped.
        do_load(12'hA5F);
        check("s4_clamp", 32'(bus.count_bcd), 32'h959);
        check("s4_err",   32'(bus.load_err), 32'h1);
        step(1);
        check("s4_err_off", 32'(bus.load_err), 32'h0);

        // Start at zero, then load colliding with the terminal tick.
        do_load(12'h000);
        d0 = done_cnt;
        do_start();
        check("s5_exp0",  32'(bus.expired), 32'h1);
        check("s5_done0", 32'(bus.done), 32'h1);
        step(1);
        do_load(12'h001);
        do_start();
        step(9);
        check("s5_pre", 32'(bus.count_bcd), 32'h001);
        do_load(12'h050);
        check("s5_coll_cnt", 32'(bus.count_bcd), 32'h050);
        check("s5_coll_st",  32'({bus.running, bus.expired, bus.done}), 32'h0);
        step(2);
        check("s5_npulse", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a run.
        do_load(12'h123);
        do_start();
        step(15);
        check("s6_pre", 32'(bus.count_bcd), 32'h122);
        d0 = done_cnt;
        reset = 1'b1;
        step(1);
        check("s6_cnt",   32'(bus.count_bcd), 32'h0);
        check("s6_flags", 32'({bus.running, bus.expired, bus.done, bus.load_err}), 32'h0);
        step(1);
        reset = 1'b0;
        check("s6_seg", 32'(bus.segments), 32'({3{7'b1000000}}));
        step(2);
        check("s6_nodone", 32'(done_cnt - d0), 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
